// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router output FIFO.
//  - WIDTH        default data byte width
//  - HDR_LEN_LSB  lowest bit of the header length field data[WIDTH-1:2]
//  - HDR_ADDR_*   header destination address field data[1:0]
//  - fifo_entry_t one queued entry: header flag plus data byte
package router_pkg;

  localparam int WIDTH        = 8;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef struct packed {
    logic             hdr;
    logic [WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: DEPTH x (WIDTH+1) register array backing the router FIFO.
// Contents are never reset. The read mux is combinational and feeds the
// registered output stage in router_fifo.
// Ports:
//  clock      in   rising-edge clock
//  i_wr_en    in   write strobe
//  i_wr_addr  in   write address
//  i_wr_data  in   {hdr, data} entry to store
//  i_rd_addr  in   read address
//  o_rd_data  out  entry currently at i_rd_addr
module router_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH:0]    i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH:0]    o_rd_data
);

  logic [WIDTH:0] r_mem [DEPTH];

  // Synchronous write port; storage has no reset by design.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/router_fifo.sv
// router_fifo: per-destination output FIFO downstream of the router register
// stage. Stores {lfd_state, data_in} per entry and tracks packet length on
// the read side so last_byte marks the parity byte of each packet.
// Ports:
//  clock       in   rising-edge clock
//  resetn      in   asynchronous active-low reset
//  soft_reset  in   synchronous clear, overrides reads and writes
//  write_enb   in   write request
//  lfd_state   in   1 = data_in is a header byte
//  data_in     in   byte from the register stage
//  read_enb    in   read request from the destination client
//  data_out    out  registered read data (1-cycle latency)
//  last_byte   out  data_out is the final byte of its packet
//  full        out  combinational full flag
//  empty       out  combinational empty flag
// Optional (macro ROUTER_FIFO_STATUS_EN):
//  count       out  occupancy, 0..DEPTH
//  overflow    out  sticky: write attempted while full
//  underflow   out  sticky: read attempted while empty
module router_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = router_pkg::WIDTH,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             last_byte,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = WIDTH - HDR_LEN_LSB;
  localparam int CNT_W  = LEN_W + 1;

  logic [ADDR_W:0]    r_wr_ptr;
  logic [ADDR_W:0]    r_rd_ptr;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_last_byte;

  logic               w_full;
  logic               w_empty;
  logic               w_wr_fire;
  logic               w_rd_fire;
  logic [WIDTH:0]     w_rd_entry;
  logic               w_rd_hdr;
  logic [LEN_W-1:0]   w_rd_len;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last_nxt;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  // Flags are pre-edge: a read from a full FIFO does not admit a same-cycle write.
  assign w_wr_fire = write_enb & ~w_full;
  assign w_rd_fire = read_enb & ~w_empty;

  router_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock     (clock),
    .i_wr_en   (w_wr_fire & ~soft_reset),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data ({lfd_state, data_in}),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_entry)
  );

  assign w_rd_hdr = w_rd_entry[WIDTH];
  assign w_rd_len = w_rd_entry[WIDTH-1:HDR_LEN_LSB];

  // Packet counter update for the entry being read; header reloads len+1 (payload + parity).
  always_comb begin
    w_cnt_nxt  = r_pkt_cnt;
    w_last_nxt = 1'b0;
    if (w_rd_hdr) begin
      w_cnt_nxt  = {1'b0, w_rd_len} + {{LEN_W{1'b0}}, 1'b1};
      w_last_nxt = 1'b0;
    end else if (r_pkt_cnt != {CNT_W{1'b0}}) begin
      w_cnt_nxt  = r_pkt_cnt - {{LEN_W{1'b0}}, 1'b1};
      w_last_nxt = (r_pkt_cnt == {{LEN_W{1'b0}}, 1'b1});
    end else begin
      // Payload byte with no open packet: deliver it, never flag it as last.
      w_cnt_nxt  = r_pkt_cnt;
      w_last_nxt = 1'b0;
    end
  end

  // Pointers, registered read data and packet tracking.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= {(ADDR_W+1){1'b0}};
      r_rd_ptr    <= {(ADDR_W+1){1'b0}};
      r_pkt_cnt   <= {CNT_W{1'b0}};
      r_data_out  <= {WIDTH{1'b0}};
      r_last_byte <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr    <= {(ADDR_W+1){1'b0}};
      r_rd_ptr    <= {(ADDR_W+1){1'b0}};
      r_pkt_cnt   <= {CNT_W{1'b0}};
      r_data_out  <= {WIDTH{1'b0}};
      r_last_byte <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (w_rd_fire) begin
        r_rd_ptr    <= r_rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
        r_data_out  <= w_rd_entry[WIDTH-1:0];
        r_pkt_cnt   <= w_cnt_nxt;
        r_last_byte <= w_last_nxt;
      end
    end
  end

  assign data_out  = r_data_out;
  assign last_byte = r_last_byte;
  assign full      = w_full;
  assign empty     = w_empty;

`ifdef ROUTER_FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags for attempted accesses that were dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (soft_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enb & w_full) begin
        r_overflow <= 1'b1;
      end
      if (read_enb & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign count     = r_wr_ptr - r_rd_ptr;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: self-checking bench for router_fifo. A queue-based
// reference model tracks queued entries, the open packet's remaining length
// and the expected output byte; directed scenarios are followed by random
// traffic. Define ROUTER_FIFO_STATUS_EN to also check count/overflow/underflow.
module tb_router_fifo;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       last_byte;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_STATUS_EN
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
`endif

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .last_byte  (last_byte),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_FIFO_STATUS_EN
    ,
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model state
  logic [8:0] mq[$];
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_last;
  bit         m_ovf;
  bit         m_unf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    m_last = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock: drive, check flags pre-edge, advance model, check outputs post-edge.
  task automatic cycle(input bit wr, input bit lfd, input logic [7:0] din,
                       input bit rd, input bit sr);
    bit         was_full;
    bit         was_empty;
    logic [8:0] e;
    write_enb  = wr;
    lfd_state  = lfd;
    data_in    = din;
    read_enb   = rd;
    soft_reset = sr;
    #1;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    chk("full", full, was_full);
    chk("empty", empty, was_empty);
    @(posedge clock);
    if (sr) begin
      model_clear();
    end else begin
      if (wr && was_full) m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
      if (rd && !was_empty) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) begin
          m_cnt  = int'(e[7:2]) + 1;
          m_last = 1'b0;
        end else if (m_cnt != 0) begin
          m_cnt  = m_cnt - 1;
          m_last = (m_cnt == 0);
        end else begin
          m_last = 1'b0;
        end
      end
      if (wr && !was_full) mq.push_back({lfd, din});
    end
    #1;
    chk("data_out", data_out, m_dout);
    chk("last_byte", last_byte, m_last);
`ifdef ROUTER_FIFO_STATUS_EN
    chk("count", count, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
`endif
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
  endtask

  task automatic wr_byte(input bit lfd, input logic [7:0] din);
    cycle(1'b1, lfd, din, 1'b0, 1'b0);
  endtask

  task automatic rd_byte();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] pkt[5];
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;
    model_clear();

    // Power-on reset state
    #3;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_last", last_byte, 1'b0);
    #9 resetn = 1'b1;

    // Packet: header len 3, three payload bytes, parity
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h3F;
    for (int i = 0; i < 5; i++) wr_byte(i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      rd_byte();
      chk("pkt_data", data_out, pkt[i]);
      chk("pkt_last", last_byte, i == 4);
    end

    // Async reset mid-cycle with a packet partly queued
    wr_byte(1'b1, 8'h09);
    wr_byte(1'b0, 8'h55);
    rd_byte();
    #2 resetn = 1'b0;
    #1;
    model_clear();
    chk("arst_empty", empty, 1'b1);
    chk("arst_full", full, 1'b0);
    chk("arst_dout", data_out, 8'h00);
    chk("arst_last", last_byte, 1'b0);
    #3 resetn = 1'b1;

    // Fill to 16, 17th write dropped, drain
    for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'(i + 1));
    chk("fill_full", full, 1'b1);
    wr_byte(1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) begin
      rd_byte();
      chk("fill_data", data_out, 8'(i + 1));
    end
    chk("fill_empty", empty, 1'b1);
    rd_byte();
    chk("rd_empty_hold", data_out, 8'h10);

    // Simultaneous read/write while full, then at 12 entries
    for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'(8'h40 + i));
    cycle(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    chk("rw_full_dout", data_out, 8'h40);
    chk("rw_full_after", full, 1'b0);
    for (int i = 0; i < 3; i++) rd_byte();
    cycle(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    n = 0;
    while (!empty && n < 20) begin
      rd_byte();
      n++;
    end
    chk("rw_occ12", n, 12);
    chk("rw_tail", data_out, 8'h5A);

    // soft_reset with 7 queued and pkt_cnt=3, then a fresh len-1 packet
    wr_byte(1'b1, 8'h0D);
    for (int i = 0; i < 8; i++) wr_byte(1'b0, 8'(8'h60 + i));
    rd_byte();
    rd_byte();
    cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
    chk("srst_empty", empty, 1'b1);
    chk("srst_last", last_byte, 1'b0);
    wr_byte(1'b1, 8'h04);
    wr_byte(1'b0, 8'h77);
    wr_byte(1'b0, 8'h88);
    rd_byte();
    chk("srst_hdr_last", last_byte, 1'b0);
    rd_byte();
    chk("srst_p1_last", last_byte, 1'b0);
    rd_byte();
    chk("srst_p2_last", last_byte, 1'b1);
    chk("srst_p2_data", data_out, 8'h88);

    // Malformed payload with no open packet, and zero-length header
    wr_byte(1'b0, 8'h99);
    wr_byte(1'b1, 8'h00);
    wr_byte(1'b0, 8'hC3);
    rd_byte();
    chk("malformed_last", last_byte, 1'b0);
    rd_byte();
    rd_byte();
    chk("len0_last", last_byte, 1'b1);

`ifdef ROUTER_FIFO_STATUS_EN
    // Sticky underflow held until soft_reset; overflow on write while full
    rd_byte();
    chk("unf_set", underflow, 1'b1);
    wr_byte(1'b0, 8'h01);
    chk("unf_hold", underflow, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr", underflow, 1'b0);
    for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'(i));
    chk("cnt16", count, 5'd16);
    wr_byte(1'b0, 8'hAA);
    chk("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 16; i++) rd_byte();
    chk("cnt0", count, 5'd0);
`endif

    // Random traffic: fill-biased phase then drain-biased phase
    for (int i = 0; i < 800; i++) begin
      bit wr, rd, lfd, sr;
      int pw, pr;
      pw  = (i < 400) ? 70 : 35;
      pr  = (i < 400) ? 40 : 70;
      wr  = ($urandom_range(0, 99) < pw);
      rd  = ($urandom_range(0, 99) < pr);
      lfd = ($urandom_range(0, 3) == 0);
      sr  = ($urandom_range(0, 199) == 0);
      cycle(wr, lfd, 8'($urandom), rd, sr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
